// File: rtl/fb_line_reader.sv
// Framebuffer line reader: fetches one line of 16-bit words from RAM
// into a show-ahead pixel FIFO. Optional macro: FB_LINE_READER_UNDERRUN_EN.
module fb_line_reader #(
  parameter int unsigned H_WORDS     = 1280,
  parameter logic [21:0] BASE_ADDR   = 22'h000000,
  parameter int unsigned LINE_STRIDE = 1280,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        frame_start,
  input  logic        line_req,
  output logic        ram_oe,
  output logic        ram_wr,
  output logic [21:0] ram_address,
  input  logic [15:0] ram_rdata,
  input  logic        ram_busy,
  input  logic        pix_rd,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic        line_done,
  output logic        underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int NW = $clog2(H_WORDS + 1);
  localparam logic [NW-1:0] H_CNT = NW'(H_WORDS);
  localparam logic [21:0] STRIDE = 22'(LINE_STRIDE);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DATA
  } state_t;

  state_t          state_q, state_d;
  logic [21:0]     addr_q, addr_d;
  logic [21:0]     line_ptr_q, line_ptr_d;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic            abort_q, abort_d;
  logic            line_done_q, line_done_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     mem_q [FIFO_DEPTH];
  logic            push;
  logic            pop;
  logic            fifo_room;

  assign fifo_room = count_q < DEPTH_C;
  assign pop       = pix_rd && (count_q != '0);

  // Fetch sequencing: one outstanding read, aborted reads drain silently
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    line_ptr_d  = line_ptr_q;
    abort_d     = abort_q;
    line_done_d = 1'b0;
    push        = 1'b0;
    ram_oe      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (line_req && (cnt_q == '0 || frame_start)) begin
          addr_d = frame_start ? BASE_ADDR : line_ptr_q;
          cnt_d  = H_CNT;
        end else if (frame_start) begin
          cnt_d = '0;
        end else if (cnt_q != '0 && !ram_busy && fifo_room) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ram_oe  = 1'b1;
        state_d = S_WAIT_BUSY;
        if (frame_start) abort_d = 1'b1;
      end
      S_WAIT_BUSY: begin
        if (frame_start) abort_d = 1'b1;
        if (ram_busy) state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (!ram_busy) begin
          state_d = S_IDLE;
          abort_d = 1'b0;
          if (!abort_q && !frame_start) begin
            push   = 1'b1;
            addr_d = addr_q + 22'd1;
            cnt_d  = cnt_q - NW'(1);
            if (cnt_q == NW'(1)) begin
              line_done_d = 1'b1;
              line_ptr_d  = line_ptr_q + STRIDE;
            end
          end
        end else if (frame_start) begin
          abort_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (frame_start) begin
      line_ptr_d = BASE_ADDR;
      if (state_q != S_IDLE) cnt_d = '0;
    end
  end

  // Pixel FIFO pointers; frame_start flushes
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (frame_start) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control and FIFO state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      line_ptr_q  <= BASE_ADDR;
      abort_q     <= 1'b0;
      line_done_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      line_ptr_q  <= line_ptr_d;
      abort_q     <= abort_d;
      line_done_q <= line_done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ram_rdata;
  end

  assign ram_wr      = 1'b0;
  assign ram_address = addr_q;
  assign pix_valid   = count_q != '0;
  assign pix_data    = pix_valid ? mem_q[rd_ptr_q] : 16'h0000;
  assign line_done   = line_done_q;

`ifdef FB_LINE_READER_UNDERRUN_EN
  logic underrun_q, underrun_d;

  // Sticky pop-while-empty flag, cleared by a new frame
  always_comb begin
    underrun_d = underrun_q | (pix_rd && count_q == '0);
    if (frame_start) underrun_d = 1'b0;
  end

  // Underrun flag register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) underrun_q <= 1'b0;
    else         underrun_q <= underrun_d;
  end

  assign underrun = underrun_q;
`else
  assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_fb_line_reader.sv
// Randomized bench for fb_line_reader with a RAM responder and
// a queue-based reference model of the fetched pixel stream.
module tb_fb_line_reader;

  localparam int          H      = 6;
  localparam logic [21:0] BASE   = 22'h3FFFFE;
  localparam int          STRIDE = 3;
  localparam int          DEPTH  = 4;
`ifdef FB_LINE_READER_UNDERRUN_EN
  localparam bit UND_EN = 1'b1;
`else
  localparam bit UND_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        frame_start = 1'b0;
  logic        line_req = 1'b0;
  logic        ram_busy = 1'b0;
  logic        pix_rd = 1'b0;
  logic [15:0] ram_rdata = 16'h0;
  logic        ram_oe, ram_wr, pix_valid, line_done, underrun;
  logic [21:0] ram_address;
  logic [15:0] pix_data;

  always #5 clk = ~clk;

  fb_line_reader #(
    .H_WORDS(H), .BASE_ADDR(BASE),
    .LINE_STRIDE(STRIDE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .resetn(resetn),
    .frame_start(frame_start), .line_req(line_req),
    .ram_oe(ram_oe), .ram_wr(ram_wr),
    .ram_address(ram_address), .ram_rdata(ram_rdata),
    .ram_busy(ram_busy), .pix_rd(pix_rd),
    .pix_data(pix_data), .pix_valid(pix_valid),
    .line_done(line_done), .underrun(underrun)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [15:0] expq[$];
  int          push_left = 0;
  int          issue_left = 0;
  logic [21:0] exp_addr = 22'h0;
  logic [21:0] line_ptr = BASE;
  bit          rd_out = 0;
  bit          rd_abort = 0;
  bit          und = 0;
  bit          ld = 0;
  logic [15:0] cur_val = 16'h0;

  // RAM responder state
  bit          ram_act = 0;
  bit          ram_done = 0;
  int          ram_gap = 0;
  int          ram_len = 0;

  logic [21:0] alog[$];
  int          n_issue = 0;
  int          ld_cnt = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    expq.delete();
    push_left  = 0;
    issue_left = 0;
    rd_out     = 0;
    rd_abort   = 0;
    line_ptr   = BASE;
    und        = 0;
    ld         = 0;
  endtask

  // model advance on each active edge, from bench-driven inputs
  always @(posedge clk) begin : model
    bit outp;
    int pl;
    int sz;
    bit do_push;
    bit do_pop;
    bit uevt;
    if (resetn) begin
      outp    = rd_out;
      pl      = push_left;
      sz      = expq.size();
      do_push = ram_done && rd_out && !rd_abort && !frame_start;
      do_pop  = pix_rd && sz > 0;
      uevt    = pix_rd && sz == 0;
      ld      = 0;
      if (ram_done) begin
        ram_done = 0;
        if (rd_out) begin
          rd_out   = 0;
          rd_abort = 0;
        end
      end
      if (frame_start) begin
        expq.delete();
        push_left  = 0;
        issue_left = 0;
        line_ptr   = BASE;
        und        = 0;
        if (rd_out) rd_abort = 1;
      end else begin
        if (do_pop) void'(expq.pop_front());
        if (do_push) begin
          expq.push_back(cur_val);
          push_left--;
          if (push_left == 0) begin
            ld       = 1;
            line_ptr = line_ptr + 22'(STRIDE);
          end
        end
        if (uevt && UND_EN) und = 1;
      end
      if (line_req && !outp && (pl == 0 || frame_start)) begin
        exp_addr   = line_ptr;
        issue_left = H;
        push_left  = H;
      end
    end
  end

  task automatic check_outputs();
    logic [15:0] head;
    head = 16'h0;
    if (expq.size() > 0) head = expq[0];
    chk("pix_valid", pix_valid, expq.size() > 0);
    chk("pix_data", pix_data, head);
    chk("line_done", line_done, ld);
    chk("underrun", underrun, und);
    chk("ram_wr", ram_wr, 0);
    if (!resetn) chk("rst_ram_address", ram_address, 0);
    if (line_done) ld_cnt++;
    if (ram_oe) begin
      chk("oe_busy_or_outstanding", {ram_busy, rd_out}, 0);
      chk("oe_expected", issue_left > 0, 1);
      chk("oe_addr", ram_address, exp_addr);
      chk("oe_fifo_room", expq.size() < DEPTH, 1);
      alog.push_back(ram_address);
      n_issue++;
      rd_out     = 1;
      rd_abort   = 0;
      issue_left--;
      exp_addr   = exp_addr + 22'd1;
    end
  endtask

  task automatic ram_step();
    if (ram_oe) begin
      ram_act = 1;
      ram_gap = $urandom_range(0, 1);
      ram_len = $urandom_range(1, 3);
      cur_val = 16'($urandom);
    end else if (ram_act) begin
      if (ram_gap > 0) begin
        ram_gap--;
      end else if (!ram_busy) begin
        ram_busy  = 1;
        ram_rdata = 16'($urandom);
      end else if (ram_len > 1) begin
        ram_len--;
        ram_rdata = 16'($urandom);
      end else begin
        ram_busy  = 0;
        ram_rdata = cur_val;
        ram_act   = 0;
        ram_done  = 1;
      end
    end
  endtask

  task automatic cyc(input bit fs, input bit lr, input bit rd);
    @(negedge clk);
    check_outputs();
    ram_step();
    frame_start = fs;
    line_req    = lr;
    pix_rd      = rd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    ram_step();
    frame_start = 0;
    line_req    = 0;
    pix_rd      = 0;
    resetn      = 0;
    ram_gap     = 0;
    model_clear();
    repeat (3) cyc(0, 0, 0);
    resetn = 1;
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((rd_out || push_left > 0 || expq.size() > 0) && t < 2000) begin
      cyc(0, 0, expq.size() > 0);
      t++;
    end
    chk(nm, t < 2000, 1);
    repeat (2) cyc(0, 0, 0);
  endtask

  initial begin
    int t;
    int base_n;
    int base_ld;
    model_clear();
    repeat (2) cyc(0, 0, 0);
    chk("rst_ram_oe", ram_oe, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_data", pix_data, 16'h0000);
    chk("rst_underrun", underrun, 0);
    resetn = 1;
    cyc(0, 0, 0);

    // line 1 with no consumer: fetch must stall at FIFO depth
    cyc(0, 1, 0);
    t = 0;
    while (!(n_issue >= DEPTH && !rd_out) && t < 300) begin
      cyc(0, 0, 0);
      t++;
    end
    chk("stall_timeout", t < 300, 1);
    repeat (20) cyc(0, 0, 0);
    chk("stall_reads", n_issue, 4);
    chk("stall_full", pix_valid, 1);
    chk("addr0", alog[0], 22'h3FFFFE);
    chk("addr1", alog[1], 22'h3FFFFF);
    chk("addr2", alog[2], 22'h000000);
    chk("addr3", alog[3], 22'h000001);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    t = 0;
    while ((rd_out || push_left > 0) && t < 300) begin
      cyc(0, 0, 0);
      t++;
    end
    chk("resume_timeout", t < 300, 1);
    repeat (3) cyc(0, 0, 0);
    chk("resume_reads", n_issue, 6);
    chk("addr4", alog[4], 22'h000002);
    chk("addr5", alog[5], 22'h000003);
    chk("line_done_count1", ld_cnt, 1);
    drain("drain1");

    // second line starts one stride later, wrapped
    cyc(0, 1, 0);
    t = 0;
    while (n_issue < 7 && t < 100) begin
      cyc(0, 0, 0);
      t++;
    end
    chk("line2_timeout", t < 100, 1);
    chk("line2_start", alog[6], 22'h000001);
    drain("drain2");
    chk("line_done_count2", ld_cnt, 2);

    // pop while empty
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("underrun_set", underrun, UND_EN);
    repeat (3) cyc(0, 0, 0);
    chk("underrun_hold", underrun, UND_EN);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("underrun_clear", underrun, 0);

    // frame_start during an in-flight read
    base_n  = n_issue;
    base_ld = ld_cnt;
    cyc(0, 1, 0);
    t = 0;
    while (!ram_busy && t < 100) begin
      cyc(0, 0, 0);
      t++;
    end
    chk("abort_timeout", t < 100, 1);
    cyc(1, 0, 0);
    t = 0;
    while (rd_out && t < 100) begin
      cyc(0, 0, 0);
      t++;
    end
    repeat (4) cyc(0, 0, 0);
    chk("abort_empty", pix_valid, 0);
    chk("abort_no_done", ld_cnt, base_ld);
    chk("abort_reads", n_issue, base_n + 1);
    cyc(0, 1, 0);
    t = 0;
    while (n_issue < base_n + 2 && t < 100) begin
      cyc(0, 0, 0);
      t++;
    end
    chk("after_abort_addr", alog[alog.size()-1], 22'h3FFFFE);
    drain("drain3");

    // simultaneous frame_start and line_req restarts at base
    base_n = n_issue;
    cyc(1, 1, 0);
    t = 0;
    while (n_issue == base_n && t < 100) begin
      cyc(0, 0, 0);
      t++;
    end
    chk("fs_lr_addr", alog[alog.size()-1], 22'h3FFFFE);
    drain("drain4");

    // randomized traffic with a mid-run reset
    for (int i = 0; i < 4000; i++) begin
      bit fs;
      bit lr;
      bit rd;
      if (i == 2000) do_reset();
      fs = ($urandom_range(0, 199) == 0);
      lr = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 2) != 0);
      if (i >= 1000 && i < 1400) rd = ($urandom_range(0, 9) == 0);
      cyc(fs, lr, rd);
    end
    drain("drain_random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
